// File: rtl/gpsdo_pkg.sv
// Shared GPSDO constants and PPS measurement FSM state type; pure declarations.
// No latency or backpressure: consumed at elaboration by the measurement and PID blocks.
package gpsdo_pkg;

  localparam int unsigned PHASE_W       = 24;
  localparam int unsigned PPS_NOMINAL   = 1_000_000;
  localparam int unsigned PPS_MIN_COUNT = 900_000;
  localparam int unsigned PPS_MAX_COUNT = 1_100_000;
  localparam int unsigned PPS_VALID_CNT = 3;

  typedef enum logic [1:0] {
    ST_ARM     = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOST    = 2'd2
  } pps_state_e;

endpackage

// File: rtl/pps_sync_edge.sv
// Two-flop synchroniser plus history flop; one-cycle pulse on a synchronised rising edge.
// Latency: pin rise sampled at edge n gives rise_o high for the cycle acted on at edge n+2; no backpressure.
module pps_sync_edge (
  input  logic CLK_SYS,
  input  logic CLK_RST,
  input  logic async_i,
  output logic rise_o
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  assign sync_d = {sync_q[1:0], async_i};

  always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
    if (!CLK_RST) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/gps_pps_measure.sv
// Measures CLK_SYS cycles between accepted GPS PPS edges and publishes them with a Done strobe.
// Latency: phase updates on the accepting edge, Done one cycle later; no backpressure (consumer must keep up).
module gps_pps_measure
  import gpsdo_pkg::*;
#(
  parameter int unsigned MIN_COUNT = PPS_MIN_COUNT,
  parameter int unsigned MAX_COUNT = PPS_MAX_COUNT,
  parameter int unsigned VALID_CNT = PPS_VALID_CNT
) (
  input  logic               CLK_SYS,
  input  logic               CLK_RST,
  input  logic               GPS_PPS,
  output logic [PHASE_W-1:0] Measure_Phase,
  output logic               Measure_Done,
  output logic               PPS_Valid,
  output logic               PPS_Lost
);

  localparam int unsigned GW = $clog2(VALID_CNT + 1);
  localparam logic [PHASE_W-1:0] MinC    = PHASE_W'(MIN_COUNT);
  localparam logic [PHASE_W-1:0] MaxC    = PHASE_W'(MAX_COUNT);
  localparam logic [GW-1:0]      GoodMax = GW'(VALID_CNT);

  pps_state_e         state_q, state_d;
  logic [PHASE_W-1:0] cnt_q, cnt_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [GW-1:0]      good_q, good_d;
  logic               pend_q, pend_d;
  logic               done_q, done_d;
  logic               valid_q, valid_d;
  logic               lost_q, lost_d;
  logic               pps_rise;
  logic [PHASE_W-1:0] cnt_inc;

  pps_sync_edge u_sync (
    .CLK_SYS (CLK_SYS),
    .CLK_RST (CLK_RST),
    .async_i (GPS_PPS),
    .rise_o  (pps_rise)
  );

  assign cnt_inc = (cnt_q == MaxC) ? MaxC : cnt_q + 1'b1;

  always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
    if (!CLK_RST) begin
      state_q <= ST_ARM;
      cnt_q   <= '0;
      phase_q <= '0;
      good_q  <= '0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      good_q  <= good_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      lost_q  <= lost_d;
    end
  end

  // Done trails the phase update by one cycle so the value is settled at its rising edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    phase_d = phase_q;
    good_d  = good_q;
    pend_d  = 1'b0;
    done_d  = pend_q;
    valid_d = valid_q;
    lost_d  = lost_q;
    if (pend_q && (good_q == GoodMax)) begin
      valid_d = 1'b1;
    end
    unique case (state_q)
      ST_ARM: begin
        if (pps_rise) begin
          cnt_d   = PHASE_W'(1);
          state_d = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        if (pps_rise && (cnt_q >= MinC)) begin
          phase_d = cnt_q;
          cnt_d   = PHASE_W'(1);
          pend_d  = 1'b1;
          if (good_q != GoodMax) begin
            good_d = good_q + 1'b1;
          end
        end else if (!pps_rise && (cnt_q == MaxC)) begin
          state_d = ST_LOST;
          lost_d  = 1'b1;
          valid_d = 1'b0;
          good_d  = '0;
        end
      end
      ST_LOST: begin
        cnt_d = cnt_q;
        if (pps_rise) begin
          cnt_d   = PHASE_W'(1);
          lost_d  = 1'b0;
          state_d = ST_MEASURE;
        end
      end
      default: state_d = ST_ARM;
    endcase
  end

  assign Measure_Phase = phase_q;
  assign Measure_Done  = done_q;
  assign PPS_Valid     = valid_q;
  assign PPS_Lost      = lost_q;

endmodule

// File: tb/tb_gps_pps_measure.sv
// Bench for gps_pps_measure with a scaled window (nominal 100, window 90..110) and an event-level model.
module tb_gps_pps_measure;
  import gpsdo_pkg::*;

  localparam int NOM  = 100;
  localparam int MINC = 90;
  localparam int MAXC = 110;
  localparam int VCNT = 3;

  logic               CLK_SYS = 1'b0;
  logic               CLK_RST = 1'b0;
  logic               GPS_PPS = 1'b0;
  logic [PHASE_W-1:0] Measure_Phase;
  logic               Measure_Done;
  logic               PPS_Valid;
  logic               PPS_Lost;

  gps_pps_measure #(
    .MIN_COUNT (MINC),
    .MAX_COUNT (MAXC),
    .VALID_CNT (VCNT)
  ) dut (
    .CLK_SYS       (CLK_SYS),
    .CLK_RST       (CLK_RST),
    .GPS_PPS       (GPS_PPS),
    .Measure_Phase (Measure_Phase),
    .Measure_Done  (Measure_Done),
    .PPS_Valid     (PPS_Valid),
    .PPS_Lost      (PPS_Lost)
  );

  always #5 CLK_SYS = ~CLK_SYS;

  int cyc = 0;
  always @(posedge CLK_SYS) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Event-level reference: acted-on rise times, last accepted edge time, publish times.
  localparam int M_ARM = 0, M_RUN = 1, M_LOST = 2;
  int rise_q[$];
  int m_state = M_ARM;
  int m_t0 = 0;
  int m_phase = 0;
  int m_good = 0;
  int m_done_at = -1;
  bit m_valid = 1'b0;
  bit m_lost = 1'b0;
  bit chk_en = 1'b0;

  always @(negedge CLK_SYS) begin
    if (!CLK_RST) begin
      rise_q.delete();
      m_state = M_ARM; m_t0 = 0; m_phase = 0; m_good = 0;
      m_done_at = -1; m_valid = 1'b0; m_lost = 1'b0;
    end else if (chk_en) begin
      if (rise_q.size() > 0 && rise_q[0] == cyc) begin
        void'(rise_q.pop_front());
        if (m_state == M_ARM || m_state == M_LOST) begin
          m_t0 = cyc; m_state = M_RUN; m_lost = 1'b0;
        end else if (cyc - m_t0 >= MINC) begin
          m_phase = cyc - m_t0;
          m_t0 = cyc;
          m_done_at = cyc + 1;
          if (m_good < VCNT) m_good++;
        end
      end
      if (m_state == M_RUN && cyc - m_t0 >= MAXC) begin
        m_state = M_LOST; m_lost = 1'b1; m_valid = 1'b0; m_good = 0;
      end
      if (cyc == m_done_at && m_good == VCNT) m_valid = 1'b1;
      chk("model_done",  int'(Measure_Done), int'(cyc == m_done_at));
      chk("model_phase", int'(Measure_Phase), m_phase);
      chk("model_valid", int'(PPS_Valid), int'(m_valid));
      chk("model_lost",  int'(PPS_Lost), int'(m_lost));
    end
  end

  task automatic step();
    @(posedge CLK_SYS);
    #1;
  endtask

  task automatic raise();
    GPS_PPS = 1'b1;
    rise_q.push_back(cyc + 3);
  endtask

  // Pulse high for width cycles; returns period cycles after the rise.
  task automatic pulse(input int width, input int period);
    raise();
    repeat (width) step();
    GPS_PPS = 1'b0;
    repeat (period - width) step();
  endtask

  typedef struct {
    int gap_after;
    bit exp_pub;
    int exp_phase;
    bit exp_valid;
  } vec_t;

  vec_t vt[9];

  initial begin
    vt[0] = '{100, 1'b0,   0, 1'b0};
    vt[1] = '{100, 1'b1, 100, 1'b0};
    vt[2] = '{105, 1'b1, 100, 1'b0};
    vt[3] = '{ 99, 1'b1, 105, 1'b1};
    vt[4] = '{110, 1'b1,  99, 1'b1};
    vt[5] = '{ 89, 1'b1, 110, 1'b1};
    vt[6] = '{ 21, 1'b0, 110, 1'b1};
    vt[7] = '{ 90, 1'b1, 110, 1'b1};
    vt[8] = '{100, 1'b1,  90, 1'b1};

    repeat (3) @(posedge CLK_SYS);
    @(negedge CLK_SYS);
    chk("rst_phase", int'(Measure_Phase), 0);
    chk("rst_done",  int'(Measure_Done), 0);
    chk("rst_valid", int'(PPS_Valid), 0);
    chk("rst_lost",  int'(PPS_Lost), 0);
    step();
    CLK_RST = 1'b1;
    chk_en = 1'b1;
    repeat (5) step();

    for (int i = 0; i < 9; i++) begin
      raise();
      repeat (2) step();
      GPS_PPS = 1'b0;
      repeat (2) step();
      @(negedge CLK_SYS);
      chk($sformatf("vec%0d_done", i),  int'(Measure_Done), int'(vt[i].exp_pub));
      chk($sformatf("vec%0d_phase", i), int'(Measure_Phase), vt[i].exp_phase);
      chk($sformatf("vec%0d_valid", i), int'(PPS_Valid), int'(vt[i].exp_valid));
      repeat (vt[i].gap_after - 4) @(posedge CLK_SYS);
      #1;
    end

    // Wide glitch pulse 30 cycles after a good edge must not disturb the measurement.
    pulse(2, 30);
    pulse(50, 70);
    pulse(2, 5);
    @(negedge CLK_SYS);
    chk("glitch_phase", int'(Measure_Phase), NOM);
    chk("glitch_valid", int'(PPS_Valid), 1);
    step();
    repeat (NOM - 7) step();

    // Missing PPS: loss flagged exactly MAXC cycles after the last accepted edge.
    pulse(2, NOM);
    repeat (12) step();
    @(negedge CLK_SYS);
    chk("lost_before", int'(PPS_Lost), 0);
    step();
    @(negedge CLK_SYS);
    chk("lost_at_max", int'(PPS_Lost), 1);
    chk("lost_valid",  int'(PPS_Valid), 0);
    repeat (30) step();
    pulse(2, NOM);
    pulse(2, NOM);
    pulse(2, NOM);
    pulse(2, NOM);
    pulse(2, 40);
    chk("pre_rst_valid", int'(PPS_Valid), 1);

    // Asynchronous reset mid-period.
    #3;
    CLK_RST = 1'b0;
    #1;
    chk("arst_phase", int'(Measure_Phase), 0);
    chk("arst_done",  int'(Measure_Done), 0);
    chk("arst_valid", int'(PPS_Valid), 0);
    chk("arst_lost",  int'(PPS_Lost), 0);
    repeat (3) step();
    CLK_RST = 1'b1;
    repeat (5) step();
    pulse(2, NOM);
    pulse(2, NOM);
    pulse(2, NOM);

    for (int i = 0; i < 30; i++) begin
      int gap;
      gap = ($urandom_range(0, 7) == 0) ? 125 : int'($urandom_range(85, 115));
      pulse(int'($urandom_range(1, 3)), gap);
    end
    repeat (130) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
